// File: rtl/node_elastic_buf.sv
`default_nettype none
// ============================================================================
//  Module   : node_elastic_buf
//  Purpose  : Valid/ready elastic buffer with DEPTH entries of slack. Beats
//             are stored in a circular array and released in order. Every
//             output is a register or a register mux selected by the read
//             pointer, so no input reaches an output combinationally.
//  Ports    : clk            - clock, rising edge
//             rst_n          - asynchronous active-low reset
//             flush          - synchronous clear of all stored beats
//             data_in        - upstream payload
//             valid_up_in    - upstream beat valid
//             ready_up_out   - buffer can accept a beat (registered)
//             data_out       - head-of-buffer payload
//             valid_down_out - head entry valid
//             ready_down_in  - downstream can accept
//             count          - number of stored beats, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module node_elastic_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in,
    output logic [CW-1:0]    count
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [CW-1:0]   c_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [c_PW-1:0]  r_wp_q, w_wp_d;
    logic [c_PW-1:0]  r_rp_q, w_rp_d;
    logic [CW-1:0]    r_count_q, w_count_d;
    logic             r_ready_q, w_ready_d;
    logic             w_valid;
    logic             w_up_fire;
    logic             w_down_fire;

    assign w_valid     = (r_count_q != '0);
    assign w_up_fire   = valid_up_in & r_ready_q;
    assign w_down_fire = w_valid & ready_down_in;

    always_comb begin
        w_wp_d    = r_wp_q;
        w_rp_d    = r_rp_q;
        w_count_d = r_count_q;
        w_ready_d = r_ready_q;
        if (flush) begin
            // Flush wins over any handshake in the same cycle.
            w_wp_d    = '0;
            w_rp_d    = '0;
            w_count_d = '0;
            w_ready_d = 1'b1;
        end else begin
            // Explicit wrap so non-power-of-two depths stay in range.
            if (w_up_fire) begin
                w_wp_d = (r_wp_q == c_LAST) ? '0 : r_wp_q + c_PW'(1);
            end
            if (w_down_fire) begin
                w_rp_d = (r_rp_q == c_LAST) ? '0 : r_rp_q + c_PW'(1);
            end
            case ({w_up_fire, w_down_fire})
                2'b10:   w_count_d = r_count_q + CW'(1);
                2'b01:   w_count_d = r_count_q - CW'(1);
                default: w_count_d = r_count_q;
            endcase
            // Ready looks at the post-update count, so a pop while full
            // reopens the input one cycle later and nothing combinational
            // crosses from the downstream side.
            w_ready_d = (w_count_d != c_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp_q    <= '0;
            r_rp_q    <= '0;
            r_count_q <= '0;
            r_ready_q <= 1'b0;
        end else begin
            r_wp_q    <= w_wp_d;
            r_rp_q    <= w_rp_d;
            r_count_q <= w_count_d;
            r_ready_q <= w_ready_d;
        end
    end

    // Storage is cleared on reset so data_out reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (w_up_fire && !flush) begin
            r_mem_q[r_wp_q] <= data_in;
        end
    end

    assign data_out       = r_mem_q[r_rp_q];
    assign valid_down_out = w_valid;
    assign ready_up_out   = r_ready_q;
    assign count          = r_count_q;

endmodule
`default_nettype wire
